fft16_twiddle_commutator: RTL and testbench

Downstream neighbour of the radix-4 first butterfly stage in the 16-point FFT. It captures the four complex butterfly outputs of each group, applies the inter-stage twiddle W16^(n·k), and stores them in a ping-pong 4×4 buffer. It then replays each frame transposed, so the second-stage butterfly receives the four operands of group k on one beat.

---
 rtl/fft16_twiddle_commutator_if.sv | 32 +++
 rtl/fft16_twiddle_commutator.sv | 191 +++++++++++++++++++
 tb/tb_fft16_twiddle_commutator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_twiddle_commutator_if.sv
// Bus between the first radix-4 butterfly stage, the twiddle commutator and the
// second stage: one butterfly group in per beat, one transposed beat out.
interface fft16_twiddle_commutator_if #(
  parameter int DW = 32
);
  logic                 in_valid;
  logic                 in_first;
  logic signed [DW-1:0] in0_re, in1_re, in2_re, in3_re;
  logic signed [DW-1:0] in0_im, in1_im, in2_im, in3_im;

  logic                 out_valid;
  logic [1:0]           out_beat;
  logic signed [DW-1:0] out0_re, out1_re, out2_re, out3_re;
  logic signed [DW-1:0] out0_im, out1_im, out2_im, out3_im;
  logic                 frame_err;

  modport master (
    output in_valid, in_first,
    output in0_re, in1_re, in2_re, in3_re, in0_im, in1_im, in2_im, in3_im,
    input  out_valid, out_beat,
    input  out0_re, out1_re, out2_re, out3_re, out0_im, out1_im, out2_im, out3_im,
    input  frame_err
  );

  modport slave (
    input  in_valid, in_first,
    input  in0_re, in1_re, in2_re, in3_re, in0_im, in1_im, in2_im, in3_im,
    output out_valid, out_beat,
    output out0_re, out1_re, out2_re, out3_re, out0_im, out1_im, out2_im, out3_im,
    output frame_err
  );
endinterface

// File: rtl/fft16_twiddle_commutator.sv
// 16-point FFT inter-stage commutator: twiddles each radix-4 group by W16^(n*k),
// stores it in a ping-pong 4x4 buffer and replays each frame transposed.
module fft16_twiddle_commutator #(
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic clk,
  input  logic reset,
  fft16_twiddle_commutator_if.slave bus
);
  localparam int PW   = DW + TW;
  localparam int FRAC = TW - 2;

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [TW-1:0] coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef struct packed {
    data_t re;
    data_t im;
  } cplx_t;

  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

  localparam prod_t HALF = prod_t'(1) <<< (FRAC - 1);

  function automatic data_t round_shift(input prod_t acc);
    return data_t'((acc + HALF) >>> FRAC);
  endfunction

  // Only the exponents n*k can take are listed; p=0 and p=4 never reach the rounder.
  function automatic cplx_t twiddle(input data_t a, input data_t b, input logic [3:0] p);
    coef_t c;
    coef_t s;
    prod_t re_acc;
    prod_t im_acc;
    cplx_t y;
    c = '0;
    s = '0;
    case (p)
      4'd1:    begin c = coef_t'(15137);  s = coef_t'(6270);   end
      4'd2:    begin c = coef_t'(11585);  s = coef_t'(11585);  end
      4'd3:    begin c = coef_t'(6270);   s = coef_t'(15137);  end
      4'd6:    begin c = coef_t'(-11585); s = coef_t'(11585);  end
      4'd9:    begin c = coef_t'(-15137); s = coef_t'(-6270);  end
      default: begin c = '0;              s = '0;              end
    endcase
    re_acc = prod_t'(a) * prod_t'(c) + prod_t'(b) * prod_t'(s);
    im_acc = prod_t'(b) * prod_t'(c) - prod_t'(a) * prod_t'(s);
    if (p == 4'd0) begin
      y.re = a;
      y.im = b;
    end else if (p == 4'd4) begin
      y.re = b;
      y.im = -a;
    end else begin
      y.re = round_shift(re_acc);
      y.im = round_shift(im_acc);
    end
    return y;
  endfunction

  data_t      in_re [4];
  data_t      in_im [4];
  cplx_t      tw_p0 [4];
  cplx_t      mem   [2][4][4];
  cplx_t      out_p1 [4];
  logic       vld_p1;
  logic [1:0] beat_p1;
  logic       frame_err_q;

  logic [1:0] grp_n;
  logic [1:0] grp_eff;
  logic       wr_en;
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] rd_beat;
  logic [1:0] bank_full;
  logic       rd_fire;
  logic       rd_done;
  rd_state_t  rd_state;
  rd_state_t  rd_next;

  assign in_re[0] = bus.in0_re;
  assign in_re[1] = bus.in1_re;
  assign in_re[2] = bus.in2_re;
  assign in_re[3] = bus.in3_re;
  assign in_im[0] = bus.in0_im;
  assign in_im[1] = bus.in1_im;
  assign in_im[2] = bus.in2_im;
  assign in_im[3] = bus.in3_im;

  assign wr_en   = bus.in_valid;
  assign grp_eff = bus.in_first ? 2'd0 : grp_n;

  // Stage p0: twiddle multiply on the incoming group, written into the buffer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      tw_p0[k] = twiddle(in_re[k], in_im[k], {2'b00, grp_eff} * 4'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem[wr_bank][grp_eff][k] <= tw_p0[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    rd_fire = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_fire = 1'b1;
          rd_next = RD_BUSY;
        end
      end
      RD_BUSY: begin
        rd_fire = 1'b1;
        if (rd_beat == 2'd3) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign rd_done = rd_fire && (rd_beat == 2'd3);

  // A resync just restarts at row 0; the stale rows are overwritten before the bank fills.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_n       <= 2'd0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      rd_beat     <= 2'd0;
      bank_full   <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= wr_en && bus.in_first && (grp_n != 2'd0);
      if (rd_fire) rd_beat <= rd_beat + 2'd1;
      if (rd_done) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
      if (wr_en) begin
        grp_n <= grp_eff + 2'd1;
        if (grp_eff == 2'd3) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end
      end
    end
  end

  // Stage p1: transposed beat register, column rd_beat of the read bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      beat_p1 <= 2'd0;
      for (int m = 0; m < 4; m++) out_p1[m] <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (rd_fire) begin
        beat_p1 <= rd_beat;
        for (int m = 0; m < 4; m++) out_p1[m] <= mem[rd_bank][m][rd_beat];
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_beat  = beat_p1;
  assign bus.frame_err = frame_err_q;
  assign bus.out0_re   = out_p1[0].re;
  assign bus.out1_re   = out_p1[1].re;
  assign bus.out2_re   = out_p1[2].re;
  assign bus.out3_re   = out_p1[3].re;
  assign bus.out0_im   = out_p1[0].im;
  assign bus.out1_im   = out_p1[1].im;
  assign bus.out2_im   = out_p1[2].im;
  assign bus.out3_im   = out_p1[3].im;

endmodule

// File: tb/tb_fft16_twiddle_commutator.sv
// Directed, table-driven bench for the FFT16 twiddle commutator: constant frame,
// wrap cases, resync, streaming and mid-readout reset.
module tb_fft16_twiddle_commutator;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  fft16_twiddle_commutator_if #(.DW(DW)) bus ();

  fft16_twiddle_commutator #(.DW(DW), .TW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Row i: inputs of group n=i, and expected outputs of beat k=i.
  typedef struct packed {
    logic [3:0][31:0] g_re;
    logic [3:0][31:0] g_im;
    logic [3:0][31:0] e_re;
    logic [3:0][31:0] e_im;
  } vec_t;

  vec_t vt [9];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_e(input int i, input int m, input int re, input int im);
    vt[i].e_re[m] = 32'(re);
    vt[i].e_im[m] = 32'(im);
  endtask

  task automatic set_in(input logic [3:0][31:0] re, input logic [3:0][31:0] im);
    bus.in0_re = re[0]; bus.in1_re = re[1]; bus.in2_re = re[2]; bus.in3_re = re[3];
    bus.in0_im = im[0]; bus.in1_im = im[1]; bus.in2_im = im[2]; bus.in3_im = im[3];
  endtask

  function automatic logic [31:0] get_re(input int m);
    case (m)
      0:       return bus.out0_re;
      1:       return bus.out1_re;
      2:       return bus.out2_re;
      default: return bus.out3_re;
    endcase
  endfunction

  function automatic logic [31:0] get_im(input int m);
    case (m)
      0:       return bus.out0_im;
      1:       return bus.out1_im;
      2:       return bus.out2_im;
      default: return bus.out3_im;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_group(input int idx, input bit first);
    set_in(vt[idx].g_re, vt[idx].g_im);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    step();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  // Call right after the edge that sampled the 4th group.
  task automatic check_beats(input int base, input string tag);
    chk($sformatf("%s_pre_valid", tag), 32'(bus.out_valid), 32'd0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk($sformatf("%s_b%0d_valid", tag, b), 32'(bus.out_valid), 32'd1);
      chk($sformatf("%s_b%0d_beat", tag, b), 32'(bus.out_beat), 32'(b));
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("%s_b%0d_out%0d_re", tag, b, m), get_re(m), vt[base+b].e_re[m]);
        chk($sformatf("%s_b%0d_out%0d_im", tag, b, m), get_im(m), vt[base+b].e_im[m]);
      end
    end
    step();
    chk($sformatf("%s_post_valid", tag), 32'(bus.out_valid), 32'd0);
    chk($sformatf("%s_post_err", tag), 32'(bus.frame_err), 32'd0);
  endtask

  logic [3:0][31:0] sre;
  logic [3:0][31:0] sim;

  initial begin
    for (int i = 0; i < 9; i++) vt[i] = '0;
    // Constant frame 1000+0j.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) vt[i].g_re[k] = 32'd1000;
    for (int b = 0; b < 4; b++) set_e(b, 0, 1000, 0);
    set_e(0, 1, 1000, 0);  set_e(0, 2, 1000, 0);  set_e(0, 3, 1000, 0);
    set_e(1, 1, 924, -383); set_e(1, 2, 707, -707); set_e(1, 3, 383, -924);
    set_e(2, 1, 707, -707); set_e(2, 2, 0, -1000);  set_e(2, 3, -707, -707);
    set_e(3, 1, 383, -924); set_e(3, 2, -707, -707); set_e(3, 3, -924, 383);
    // Wrap frame: p=1 on full-scale input, p=4 negation of -2^31.
    vt[5].g_re[1] = 32'h7FFF_FFFF;
    vt[5].g_im[1] = 32'h7FFF_FFFF;
    vt[6].g_re[2] = 32'h8000_0000;
    vt[5].e_re[1] = 32'hA73D_FFFF;
    vt[5].e_im[1] = 32'h4545_FFFF;
    vt[6].e_re[2] = 32'h0000_0000;
    vt[6].e_im[2] = 32'h8000_0000;
    // Garbage partial-frame data.
    for (int k = 0; k < 4; k++) begin
      vt[8].g_re[k] = 32'd7777;
      vt[8].g_im[k] = 32'(-5555);
    end

    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    set_in('0, '0);
    reset = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_beat", 32'(bus.out_beat), 32'd0);
    chk("rst_out0_re", get_re(0), 32'd0);
    chk("rst_out3_im", get_im(3), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    reset = 1'b1;
    step();
    chk("rel_valid", 32'(bus.out_valid), 32'd0);

    // Constant frame, one group every 4th cycle.
    for (int i = 0; i < 4; i++) begin
      drive_group(i, i == 0);
      if (i < 3) repeat (3) step();
    end
    check_beats(0, "const");
    chk("hold_out3_re", get_re(3), 32'(-924));
    chk("hold_out3_im", get_im(3), 32'd383);

    // Wrap frame, back-to-back groups.
    for (int i = 0; i < 4; i++) drive_group(4 + i, i == 0);
    check_beats(4, "wrap");

    // Resync after a 2-group partial frame.
    drive_group(8, 1'b1);
    chk("rs_g0_err", 32'(bus.frame_err), 32'd0);
    drive_group(8, 1'b0);
    chk("rs_g1_err", 32'(bus.frame_err), 32'd0);
    drive_group(0, 1'b1);
    chk("rs_err_pulse", 32'(bus.frame_err), 32'd1);
    drive_group(1, 1'b0);
    chk("rs_err_clear", 32'(bus.frame_err), 32'd0);
    chk("rs_n1_valid", 32'(bus.out_valid), 32'd0);
    drive_group(2, 1'b0);
    chk("rs_n2_valid", 32'(bus.out_valid), 32'd0);
    drive_group(3, 1'b0);
    check_beats(0, "resync");

    // Three frames streamed with in_valid held high for 12 cycles.
    for (int c = 0; c < 17; c++) begin
      for (int k = 0; k < 4; k++) begin
        sre[k] = 32'(100 * (c / 4) + 10 * (c % 4) + k);
        sim[k] = 32'd0;
      end
      set_in(sre, sim);
      bus.in_valid = (c < 12);
      bus.in_first = (c < 12) && (c % 4 == 0);
      step();
      if (c == 3) chk("st_pre_valid", 32'(bus.out_valid), 32'd0);
      if (c >= 4 && c < 16) begin
        chk($sformatf("st_c%0d_valid", c), 32'(bus.out_valid), 32'd1);
        chk($sformatf("st_c%0d_beat", c), 32'(bus.out_beat), 32'((c - 4) % 4));
        chk($sformatf("st_c%0d_out0_re", c), get_re(0), 32'(100 * ((c - 4) / 4) + (c - 4) % 4));
        if ((c - 4) % 4 == 0)
          chk($sformatf("st_c%0d_out1_re", c), get_re(1), 32'(100 * ((c - 4) / 4) + 10));
        if ((c - 4) % 4 == 2)
          chk($sformatf("st_c%0d_out2_im", c), get_im(2), 32'(-(100 * ((c - 4) / 4) + 22)));
        chk($sformatf("st_c%0d_err", c), 32'(bus.frame_err), 32'd0);
      end
      if (c == 16) chk("st_post_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;

    // Reset asserted while beat 2 is on the outputs.
    for (int i = 0; i < 4; i++) drive_group(i, i == 0);
    repeat (3) step();
    chk("rr_b2_valid", 32'(bus.out_valid), 32'd1);
    chk("rr_b2_beat", 32'(bus.out_beat), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("rr_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rr_async_beat", 32'(bus.out_beat), 32'd0);
    chk("rr_async_out2_im", get_im(2), 32'd0);
    chk("rr_async_out1_re", get_re(1), 32'd0);
    #2 reset = 1'b1;
    step();
    for (int c = 0; c < 8; c++) chk($sformatf("rr_idle%0d_valid", c), 32'(bus.out_valid), 32'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("rr_wait%0d_valid", c), 32'(bus.out_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive_group(i, i == 0);
      if (i < 3) chk($sformatf("rr_g%0d_valid", i), 32'(bus.out_valid), 32'd0);
    end
    check_beats(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
